id_ex_stage: RTL and testbench

ID/EX pipeline stage for the pipelined MIPS core. It sits directly downstream of the main control decoder, which drives RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc and RegWrite. Each cycle it captures those control bits together with the ID-stage operands into the EX stage. It also contains the load-use hazard detector, which stalls IF/ID and inserts bubbles, and it accepts a flush from branch/jump resolution.

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush handling.
// Captures decoder control bits and ID operands into EX each cycle. It inserts
// a bubble on a load-use hazard or on a flush, and counts the bubbles inserted.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_RegDst,
   input  logic              id_Jump,
   input  logic              id_Branch,
   input  logic              id_MemRead,
   input  logic              id_MemtoReg,
   input  logic              id_MemWrite,
   input  logic              id_ALUSrc,
   input  logic              id_RegWrite,
   input  logic [1:0]        id_ALUOp,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [5:0]        id_funct,
   input  logic              flush,
   output logic              ex_RegDst,
   output logic              ex_Jump,
   output logic              ex_Branch,
   output logic              ex_MemRead,
   output logic              ex_MemtoReg,
   output logic              ex_MemWrite,
   output logic              ex_ALUSrc,
   output logic              ex_RegWrite,
   output logic [1:0]        ex_ALUOp,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [5:0]        ex_funct,
   output logic              pc_write,
   output logic              ifid_write,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Everything the EX stage holds. An all-zero value is a no-op bubble.
   typedef struct packed {
      logic              reg_dst;
      logic              jump;
      logic              branch;
      logic              mem_read;
      logic              mem_to_reg;
      logic              mem_write;
      logic              alu_src;
      logic              reg_write;
      logic [1:0]        alu_op;
      logic              valid;
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [5:0]        funct;
   } ex_t;

   ex_t  ex_q;
   ex_t  ex_next;
   logic hazard;
   logic bubble;

   // The load in EX writes a register that the ID instruction reads. $0 never
   // conflicts. rt is compared even when the instruction does not read it.
   assign hazard = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rt != 5'd0) &
                   ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

   // A flush overrides the stall so that IF can redirect.
   assign pc_write   = ~hazard | flush;
   assign ifid_write = ~hazard | flush;
   assign bubble     = flush | hazard;

   // Next EX contents: a bubble, or ID copied with stores and writebacks gated when ID is invalid.
   always_comb begin
      // NOTE: default everything first so no path leaves a field unassigned (no latch).
      ex_next = '0;
      if (!bubble) begin
         ex_next.reg_dst    = id_RegDst;
         ex_next.jump       = id_Jump;
         ex_next.branch     = id_Branch;
         ex_next.mem_read   = id_MemRead;
         ex_next.mem_to_reg = id_MemtoReg;
         ex_next.mem_write  = id_MemWrite & id_valid;
         ex_next.alu_src    = id_ALUSrc;
         ex_next.reg_write  = id_RegWrite & id_valid;
         ex_next.alu_op     = id_ALUOp;
         ex_next.valid      = id_valid;
         ex_next.pc4        = id_pc4;
         ex_next.rs_data    = id_rs_data;
         ex_next.rt_data    = id_rt_data;
         ex_next.imm        = id_imm;
         ex_next.rs         = id_rs;
         ex_next.rt         = id_rt;
         ex_next.rd         = id_rd;
         ex_next.funct      = id_funct;
      end
   end

   // EX pipeline register, cleared asynchronously to a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignment so all flops sample pre-edge values together.
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_next;
   end

   // Saturating count of bubble cycles; flush and hazard together count once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         bubble_cnt <= '0;
      else if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
   end

   assign ex_RegDst   = ex_q.reg_dst;
   assign ex_Jump     = ex_q.jump;
   assign ex_Branch   = ex_q.branch;
   assign ex_MemRead  = ex_q.mem_read;
   assign ex_MemtoReg = ex_q.mem_to_reg;
   assign ex_MemWrite = ex_q.mem_write;
   assign ex_ALUSrc   = ex_q.alu_src;
   assign ex_RegWrite = ex_q.reg_write;
   assign ex_ALUOp    = ex_q.alu_op;
   assign ex_valid    = ex_q.valid;
   assign ex_pc4      = ex_q.pc4;
   assign ex_rs_data  = ex_q.rs_data;
   assign ex_rt_data  = ex_q.rt_data;
   assign ex_imm      = ex_q.imm;
   assign ex_rs       = ex_q.rs;
   assign ex_rt       = ex_q.rt;
   assign ex_rd       = ex_q.rd;
   assign ex_funct    = ex_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, pass-through, load-use stall,
// false-stall cases, flush priority, invalid-ID gating and counter saturation.
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst_n;
   logic              id_RegDst, id_Jump, id_Branch, id_MemRead;
   logic              id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
   logic [1:0]        id_ALUOp;
   logic              id_valid;
   logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
   logic [4:0]        id_rs, id_rt, id_rd;
   logic [5:0]        id_funct;
   logic              flush;
   logic              ex_RegDst, ex_Jump, ex_Branch, ex_MemRead;
   logic              ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
   logic [1:0]        ex_ALUOp;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]        ex_rs, ex_rt, ex_rd;
   logic [5:0]        ex_funct;
   logic              pc_write, ifid_write;
   logic [CNT_W-1:0]  bubble_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_RegDst(id_RegDst), .id_Jump(id_Jump), .id_Branch(id_Branch),
      .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
      .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp),
      .id_valid(id_valid), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
      .ex_RegDst(ex_RegDst), .ex_Jump(ex_Jump), .ex_Branch(ex_Branch),
      .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
      .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp),
      .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_funct(ex_funct),
      .pc_write(pc_write), .ifid_write(ifid_write), .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      {id_RegDst, id_Jump, id_Branch, id_MemRead} = '0;
      {id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite} = '0;
      id_ALUOp = 2'b00; id_valid = 1'b0;
      id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0;
   endtask

   // lw rt, imm(rs)
   task automatic load_lw(input logic [4:0] rs, input logic [4:0] rt);
      clear_id();
      id_valid = 1'b1; id_MemRead = 1'b1; id_MemtoReg = 1'b1;
      id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_rs = rs; id_rt = rt; id_imm = 32'd4;
   endtask

   // add rd, rs, rt
   task automatic load_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      clear_id();
      id_valid = 1'b1; id_RegDst = 1'b1; id_ALUOp = 2'b10; id_RegWrite = 1'b1;
      id_rs = rs; id_rt = rt; id_rd = rd; id_funct = 6'h20;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      clear_id();
      #12;

      // Reset state
      check("rst_valid", 64'(ex_valid), 64'd0);
      check("rst_cnt", 64'(bubble_cnt), 64'd0);
      check("rst_pc_write", 64'(pc_write), 64'd1);
      rst_n = 1'b1;
      step();
      check("idle_valid", 64'(ex_valid), 64'd0);

      // R-format pass-through
      load_add(5'd8, 5'd9, 5'd10);
      id_MemtoReg = 1'b1; id_rs_data = 32'h11; id_rt_data = 32'h22;
      id_imm = 32'h33; id_pc4 = 32'h104;
      #1 check("r_pc_write_pre", 64'(pc_write), 64'd1);
      step();
      check("r_ctrl", 64'({ex_RegDst, ex_Jump, ex_Branch, ex_MemRead, ex_MemtoReg,
                            ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp}), 64'b1000100110);
      check("r_valid", 64'(ex_valid), 64'd1);
      check("r_regs", 64'({ex_rs, ex_rt, ex_rd, ex_funct}), 64'({5'd8, 5'd9, 5'd10, 6'h20}));
      check("r_rs_data", 64'(ex_rs_data), 64'h11);
      check("r_rt_data", 64'(ex_rt_data), 64'h22);
      check("r_imm_pc4", 64'({ex_imm, ex_pc4}), 64'h0000_0033_0000_0104);
      check("r_no_stall", 64'({pc_write, ifid_write}), 64'b11);
      check("r_cnt", 64'(bubble_cnt), 64'd0);

      // Load-use: lw $9 in EX, add reading $9 in ID
      load_lw(5'd8, 5'd9);
      step();
      load_add(5'd9, 5'd11, 5'd12);
      #1 check("lu_stall", 64'({pc_write, ifid_write}), 64'b00);
      step();
      check("lu_bubble", 64'({ex_valid, ex_RegWrite, ex_MemRead}), 64'b000);
      check("lu_cnt", 64'(bubble_cnt), 64'd1);
      check("lu_release", 64'(pc_write), 64'd1);
      step();
      check("lu_add_valid", 64'({ex_valid, ex_RegWrite}), 64'b11);
      check("lu_add_regs", 64'({ex_rs, ex_rd}), 64'({5'd9, 5'd12}));
      check("lu_add_cnt", 64'(bubble_cnt), 64'd1);

      // lw to $0 never stalls
      load_lw(5'd8, 5'd0);
      step();
      load_add(5'd0, 5'd0, 5'd12);
      #1 check("zero_no_stall", 64'(pc_write), 64'd1);
      step();
      check("zero_valid", 64'(ex_valid), 64'd1);
      check("zero_cnt", 64'(bubble_cnt), 64'd1);

      // lw $9 followed by a reader of $8/$10 does not stall
      load_lw(5'd8, 5'd9);
      step();
      load_add(5'd8, 5'd10, 5'd12);
      #1 check("indep_no_stall", 64'({pc_write, ifid_write}), 64'b11);
      step();
      check("indep_ex", 64'({ex_valid, ex_rs}), 64'({1'b1, 5'd8}));
      check("indep_cnt", 64'(bubble_cnt), 64'd1);

      // Flush together with a hazard: one bubble, PC not held
      load_lw(5'd8, 5'd9);
      step();
      load_add(5'd9, 5'd11, 5'd12);
      flush = 1'b1;
      #1 check("fh_pc_write", 64'({pc_write, ifid_write}), 64'b11);
      step();
      check("fh_bubble", 64'({ex_valid, ex_RegWrite}), 64'b00);
      check("fh_cnt", 64'(bubble_cnt), 64'd2);

      // Flush alone with a valid sw in ID
      clear_id();
      id_valid = 1'b1; id_MemWrite = 1'b1; id_ALUSrc = 1'b1; id_rs = 5'd8; id_rt = 5'd9;
      step();
      check("fsw_memwrite", 64'({ex_MemWrite, ex_valid}), 64'b00);
      check("fsw_cnt", 64'(bubble_cnt), 64'd3);
      flush = 1'b0;
      step();
      check("sw_pass", 64'({ex_MemWrite, ex_ALUSrc, ex_valid}), 64'b111);

      // Invalid ID: controls copied, writes and valid gated
      clear_id();
      id_RegWrite = 1'b1; id_MemWrite = 1'b1; id_MemRead = 1'b1; id_Branch = 1'b1;
      id_rt = 5'd9;
      step();
      check("inv_gate", 64'({ex_valid, ex_RegWrite, ex_MemWrite}), 64'b000);
      check("inv_copy", 64'({ex_Branch, ex_MemRead, ex_rt}), 64'({1'b1, 1'b1, 5'd9}));
      load_add(5'd9, 5'd9, 5'd1);
      #1 check("inv_no_stall", 64'(pc_write), 64'd1);
      check("inv_cnt", 64'(bubble_cnt), 64'd3);

      // Saturation: 20 consecutive flushes with a 4-bit counter
      flush = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         check($sformatf("sat_%0d", i), 64'(bubble_cnt), (3 + i > 15) ? 64'd15 : 64'(3 + i));
      end
      flush = 1'b0;

      // Reset asserted mid-stall clears immediately
      load_lw(5'd31, 5'd31);
      step();
      id_RegDst = 1'b1; id_Jump = 1'b1; id_Branch = 1'b1; id_MemRead = 1'b1;
      id_MemtoReg = 1'b1; id_MemWrite = 1'b1; id_ALUSrc = 1'b1; id_RegWrite = 1'b1;
      id_ALUOp = 2'b11; id_valid = 1'b1; id_pc4 = '1; id_rs_data = '1;
      id_rt_data = '1; id_imm = '1; id_rs = 5'd31; id_rt = 5'd31; id_rd = 5'd31;
      id_funct = 6'h3f;
      #1 check("pre_rst_stall", 64'(pc_write), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctrl", 64'({ex_RegDst, ex_Jump, ex_Branch, ex_MemRead, ex_MemtoReg,
                              ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp, ex_valid}), 64'd0);
      check("arst_data", 64'(ex_pc4 | ex_rs_data | ex_rt_data | ex_imm), 64'd0);
      check("arst_regs", 64'({ex_rs, ex_rt, ex_rd, ex_funct}), 64'd0);
      check("arst_cnt", 64'(bubble_cnt), 64'd0);
      check("arst_write", 64'({pc_write, ifid_write}), 64'b11);
      clear_id();
      #2 rst_n = 1'b1;
      step();
      check("post_rst", 64'({ex_valid, bubble_cnt}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
